uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver that replaces the fixed 8-bit, fixed-divide receiver.
- Samples an asynchronous serial line and reassembles frames with 5–9 data bits, optional parity and 1–2 stop bits.
- Reports parity, framing and overrun errors.
- Presents each received word through a one-entry valid/ready holding register to the APB-side logic.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit; must be ≥4 and even.
- DATA_BITS, 8: data bits per frame, 5..9; LSB first on the line.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits checked, 1 or 2.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous, active-low reset.
- wr, input, 1: receive enable; 0 aborts any frame and holds the FSM in IDLE.
- Rx, input, 1: asynchronous serial line; idles high.
- data_ready, input, 1: consumer accepts data_out this cycle.
- data_out, output, DATA_BITS: received word, valid while data_valid=1.
- data_valid, output, 1: holding register full.
- parity_err, output, 1: parity mismatch on the word in the holding register; qualified by data_valid.
- frame_err, output, 1: one-cycle pulse; a stop bit was sampled low.
- overrun, output, 1: one-cycle pulse; a completed word was discarded because the holding register was full.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - All outputs are 0.
  - Both synchroniser flops are set to 1.
  - FSM goes to IDLE and all counters are cleared.
- Synchroniser: Rx passes through 2 flops. The second flop, rx_s, is the only value the FSM uses.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - If wr=1 and rx_s=0, go to START and clear the bit-timer.
- START:
  - Count CLKS_PER_BIT/2 cycles, then sample rx_s (mid start bit).
  - If rx_s=1, treat it as a false start and return to IDLE. No flags.
  - Otherwise go to DATA with the bit-timer cleared.
- Bit sampling (DATA, PARITY, STOP): sample rx_s each time the bit-timer reaches CLKS_PER_BIT-1; the timer then wraps to 0.
- DATA:
  - Shift each sample into the shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY:
  - Sample one bit.
  - Error if the XOR of the data bits and the parity bit does not equal PARITY_ODD.
- STOP:
  - Sample STOP_BITS bits.
  - If any stop sample is 0: pulse frame_err for 1 cycle, discard the word and go to BREAK.
  - If all stop samples are 1: go to IDLE on the cycle after the last stop sample, and deliver the word (see Delivery).
- Delivery (on the cycle after the last stop sample):
  - If data_valid=0, or data_valid=1 with data_ready=1: load data_out and parity_err, and assert data_valid.
  - Otherwise keep the old data_out and pulse overrun for 1 cycle.
- BREAK:
  - Stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - data_valid=1 with data_ready=1 clears data_valid at the next edge, unless a new word loads on the same edge, in which case data_valid stays 1 with the new data.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_ready with data_valid=0 has no effect.
- wr=0 (mid-frame abort):
  - The FSM returns to IDLE at the next edge; the partial frame is dropped without flags.
  - The holding register and its handshake keep operating.
- Latency: data_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+STOP_BITS)·CLKS_PER_BIT + 1 cycles (±1) after the Rx falling edge.
- Tolerance: correct reception at ±3% baud mismatch for CLKS_PER_BIT ≥ 16.
- Reset mid-frame: the frame is discarded, all state and outputs are cleared, and no flags pulse.

Test Plan:
- Default params (16/8/no parity/1 stop), wr=1, send 0xA5, data_ready=1 → one data_valid pulse with data_out=0xA5 at 2+8+9·16+1=155 (±1) cycles after the falling edge; parity_err=0.
- PARITY_EN=1 even: send 0xA5 with parity bit 0 → data_out=0xA5, parity_err=0. Resend with parity bit 1 → data_out=0xA5, parity_err=1.
- Start-bit glitch: Rx low for 4 cycles, then high → busy rises, then returns to 0 after 8 cycles; no data_valid, no flags.
- Stop bit forced 0 while sending 0x3C → frame_err pulses 1 cycle, no data_valid.
  - Then hold Rx low 100 cycles → FSM remains in BREAK, busy=1, no new frame.
  - Release Rx high, send 0x11 → data_out=0x11.
- data_ready=0: send 0x12 then 0x34 → data_out stays 0x12 and overrun pulses once at the end of the second frame. Raise data_ready → data_valid drops.
- Back-to-back/abort: DATA_BITS=9, STOP_BITS=2.
  - Send 0x1FF then 0x000 with no idle gap → both words received in order.
  - Drop wr mid-frame → busy=0 next cycle, no output.
  - Assert rst=0 mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, optional parity,
// 1..2 stop bits) with a one-entry valid/ready holding register on the output.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 Rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned   TW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned   CW       = 4;
  localparam logic [TW-1:0] HalfLast = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DataLast = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] StopLast = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   half_tick, bit_tick;

  assign half_tick = (timer_q == HalfLast);
  assign bit_tick  = (timer_q == BitLast);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; wr=0 forces IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!wr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (!rx_s_q) state_d = StStart;
        StStart:  if (half_tick) state_d = rx_s_q ? StIdle : StData;
        StData: begin
          if (bit_tick && cnt_q == DataLast) state_d = PARITY_EN ? StParity : StStop;
        end
        StParity: if (bit_tick) state_d = StStop;
        StStop: begin
          if (bit_tick) begin
            if (!rx_s_q)               state_d = StBreak;
            else if (cnt_q == StopLast) state_d = StIdle;
          end
        end
        StBreak:  if (rx_s_q) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Bit timing, shift register, parity and stop checking.
  always_comb begin
    timer_d     = '0;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    if (wr) begin
      unique case (state_q)
        StStart: begin
          timer_d   = half_tick ? '0 : timer_q + 1'b1;
          cnt_d     = '0;
          par_bad_d = 1'b0;
        end
        StData: begin
          timer_d = bit_tick ? '0 : timer_q + 1'b1;
          if (bit_tick) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            cnt_d   = (cnt_q == DataLast) ? '0 : cnt_q + 1'b1;
          end
        end
        StParity: begin
          timer_d = bit_tick ? '0 : timer_q + 1'b1;
          if (bit_tick) par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
        end
        StStop: begin
          timer_d = bit_tick ? '0 : timer_q + 1'b1;
          if (bit_tick) begin
            cnt_d = cnt_q + 1'b1;
            if (!rx_s_q)                frame_err_d = 1'b1;
            else if (cnt_q == StopLast) done_d      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Holding register: a completed word loads one cycle after its last stop sample.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (data_valid_q && data_ready) data_valid_d = 1'b0;
    if (done_q) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        parity_err_d = par_bad_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Synchroniser, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      timer_q      <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= Rx;
      rx_s_q       <= rx_meta_q;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs.
  always_comb begin
    busy       = (state_q != StIdle);
    data_out   = data_out_q;
    data_valid = data_valid_q;
    parity_err = parity_err_q;
    frame_err  = frame_err_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (default, even parity, 9 data + 2 stop)
// checked every cycle against a frame-level event schedule plus directed literals.
module tb_uart_rx_param;

  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr[3], rx[3], rdy[3];
  logic [7:0] dout_a, dout_b;
  logic [8:0] dout_c;
  logic       dv[3], pe[3], fe[3], ov[3], bz[3];
  logic [8:0] dout[3];

  always #5 clk = ~clk;

  assign dout[0] = {1'b0, dout_a};
  assign dout[1] = {1'b0, dout_b};
  assign dout[2] = dout_c;

  uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                  .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .wr(wr[0]), .Rx(rx[0]), .data_ready(rdy[0]), .data_out(dout_a),
    .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0])
  );
  uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
                  .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .wr(wr[1]), .Rx(rx[1]), .data_ready(rdy[1]), .data_out(dout_b),
    .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1])
  );
  uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(9), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
                  .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .wr(wr[2]), .Rx(rx[2]), .data_ready(rdy[2]), .data_out(dout_c),
    .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2])
  );

  // One scheduled event: a word completing (delivery edge) or a bad stop sample.
  typedef struct {
    int         cyc;
    int         inst;
    bit         is_fe;
    logic [8:0] word;
    bit         perr;
  } ev_t;

  ev_t        sched[$];
  int         cyc;
  int         checks;
  int         failures;
  bit         m_dv[3], m_pe[3], m_fe[3], m_ov[3];
  logic [8:0] m_do[3];
  int         ov_seen[3], fe_seen[3];
  logic [8:0] c_log[$];
  bit         rand_rdy;

  task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on instance inst, starting right after the current edge, and
  // schedule its outcome. bad_stop < 0 means all stop bits are high.
  task automatic send(input int inst, input logic [8:0] w, input bit bad_par,
                      input int bad_stop);
    int         db, pen, ns, e0;
    logic [8:0] wm;
    logic       par;
    ev_t        ev;
    db  = (inst == 2) ? 9 : 8;
    pen = (inst == 1) ? 1 : 0;
    ns  = (inst == 2) ? 2 : 1;
    wm  = (inst == 2) ? w : {1'b0, w[7:0]};
    par = (^wm) ^ bad_par;
    e0  = cyc;
    // Mid-bit sample n (start bit is n=0) lands at edge e0 + 3 + Cpb/2 + n*Cpb.
    ev.inst  = inst;
    ev.word  = wm;
    ev.perr  = bad_par;
    ev.is_fe = (bad_stop >= 0);
    if (bad_stop >= 0) ev.cyc = e0 + 3 + Cpb / 2 + (db + pen + 1 + bad_stop) * Cpb;
    else               ev.cyc = e0 + 4 + Cpb / 2 + (db + pen + ns) * Cpb;
    sched.push_back(ev);
    rx[inst] = 1'b0;
    tick(Cpb);
    for (int b = 0; b < db; b++) begin
      rx[inst] = wm[b];
      tick(Cpb);
    end
    if (pen != 0) begin
      rx[inst] = par;
      tick(Cpb);
    end
    for (int s = 0; s < ns; s++) begin
      rx[inst] = (s != bad_stop);
      tick(Cpb);
    end
  endtask

  // Reference model: holding register and pulses advanced once per edge.
  initial begin
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      m_dv[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_ov[i] = 0; m_do[i] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          m_dv[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_ov[i] = 0; m_do[i] = '0;
        end
      end else begin
        bit old[3];
        for (int i = 0; i < 3; i++) begin
          old[i]  = m_dv[i];
          m_fe[i] = 0;
          m_ov[i] = 0;
          if (old[i] && rdy[i]) m_dv[i] = 0;
        end
        while (sched.size() > 0 && sched[0].cyc <= cyc) begin
          ev_t e;
          e = sched.pop_front();
          checks++;
          if (e.cyc < cyc) begin
            failures++;
            $display("FAIL sched_stale cyc=%0d actual=late required=%0d", cyc, e.cyc);
          end else if (e.is_fe) begin
            m_fe[e.inst] = 1;
          end else if (!old[e.inst] || rdy[e.inst]) begin
            m_dv[e.inst] = 1;
            m_do[e.inst] = e.word;
            m_pe[e.inst] = e.perr;
          end else begin
            m_ov[e.inst] = 1;
          end
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    for (int i = 0; i < 3; i++) begin
      ov_seen[i] = 0;
      fe_seen[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("data_valid%0d", i), {8'd0, dv[i]}, {8'd0, m_dv[i]});
        cmp($sformatf("frame_err%0d", i), {8'd0, fe[i]}, {8'd0, m_fe[i]});
        cmp($sformatf("overrun%0d", i), {8'd0, ov[i]}, {8'd0, m_ov[i]});
        if (m_dv[i]) begin
          cmp($sformatf("data_out%0d", i), dout[i], m_do[i]);
          cmp($sformatf("parity_err%0d", i), {8'd0, pe[i]}, {8'd0, m_pe[i]});
        end
        if (ov[i] === 1'b1) ov_seen[i]++;
        if (fe[i] === 1'b1) fe_seen[i]++;
      end
      if (dv[2] === 1'b1) c_log.push_back(dout[2]);
    end
  end

  // Random data_ready when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) for (int i = 0; i < 3; i++) rdy[i] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int         e0, lat, ov0, fe0;
    logic [8:0] a_word;
    logic       a_pe;
    checks   = 0;
    failures = 0;
    rand_rdy = 0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b1; rx[i] = 1'b1; rdy[i] = 1'b1;
    end
    tick(3);
    for (int i = 0; i < 3; i++) begin
      cmp("rst_valid", {8'd0, dv[i]}, 9'd0);
      cmp("rst_busy", {8'd0, bz[i]}, 9'd0);
      cmp("rst_dout", dout[i], 9'd0);
    end
    rst = 1'b1;
    tick(2);

    // 0xA5 on defaults: latency from first edge that sees the line low.
    e0 = cyc; lat = -1; a_word = '0; a_pe = 1'b1;
    fork
      send(0, 9'h0A5, 1'b0, -1);
      begin
        for (int k = 0; k < 400 && lat < 0; k++) begin
          @(negedge clk);
          if (dv[0] === 1'b1) begin
            lat = cyc - e0; a_word = dout[0]; a_pe = pe[0];
          end
        end
      end
    join
    cmp("latency_a5", 9'(lat - 1), 9'd155);
    cmp("word_a5", a_word, 9'h0A5);
    cmp("perr_a5", {8'd0, a_pe}, 9'd0);
    cmp("a5_single_pulse", {8'd0, dv[0]}, 9'd0);

    // Even parity: correct then flipped parity bit.
    rdy[1] = 1'b0;
    send(1, 9'h0A5, 1'b0, -1);
    tick(4);
    cmp("par_ok_valid", {8'd0, dv[1]}, 9'd1);
    cmp("par_ok_word", dout[1], 9'h0A5);
    cmp("par_ok_err", {8'd0, pe[1]}, 9'd0);
    rdy[1] = 1'b1; tick(1); rdy[1] = 1'b0;
    send(1, 9'h0A5, 1'b1, -1);
    tick(4);
    cmp("par_bad_word", dout[1], 9'h0A5);
    cmp("par_bad_err", {8'd0, pe[1]}, 9'd1);
    rdy[1] = 1'b1;
    tick(2);

    // Start-bit glitch: 4 low cycles.
    rx[0] = 1'b0;
    tick(4);
    cmp("glitch_busy_on", {8'd0, bz[0]}, 9'd1);
    rx[0] = 1'b1;
    tick(6);
    cmp("glitch_busy_last", {8'd0, bz[0]}, 9'd1);
    tick(1);
    cmp("glitch_busy_off", {8'd0, bz[0]}, 9'd0);
    tick(10);

    // Bad stop bit, then a held-low line, then recovery.
    fe0 = fe_seen[0];
    send(0, 9'h03C, 1'b0, 0);
    tick(100);
    cmp("frame_err_count", 9'(fe_seen[0] - fe0), 9'd1);
    cmp("break_busy", {8'd0, bz[0]}, 9'd1);
    rx[0] = 1'b1;
    tick(8);
    cmp("break_exit", {8'd0, bz[0]}, 9'd0);
    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, -1);
    tick(4);
    cmp("after_break_word", dout[0], 9'h011);
    rdy[0] = 1'b1;
    tick(2);

    // Overrun: two words with the consumer stalled.
    rdy[0] = 1'b0;
    ov0 = ov_seen[0];
    send(0, 9'h012, 1'b0, -1);
    send(0, 9'h034, 1'b0, -1);
    tick(10);
    cmp("overrun_keep_word", dout[0], 9'h012);
    cmp("overrun_count", 9'(ov_seen[0] - ov0), 9'd1);
    rdy[0] = 1'b1;
    tick(1);
    cmp("overrun_drain", {8'd0, dv[0]}, 9'd0);
    tick(2);

    // 9 data bits, 2 stops: back-to-back words.
    c_log.delete();
    send(2, 9'h1FF, 1'b0, -1);
    send(2, 9'h000, 1'b0, -1);
    tick(10);
    cmp("b2b_count", 9'(c_log.size()), 9'd2);
    if (c_log.size() == 2) begin
      cmp("b2b_first", c_log[0], 9'h1FF);
      cmp("b2b_second", c_log[1], 9'h000);
    end

    // Abort mid-frame with wr.
    rx[2] = 1'b0; tick(16);
    rx[2] = 1'b1; tick(16);
    rx[2] = 1'b0; tick(10);
    cmp("abort_busy_before", {8'd0, bz[2]}, 9'd1);
    wr[2] = 1'b0;
    tick(1);
    cmp("abort_busy_after", {8'd0, bz[2]}, 9'd0);
    rx[2] = 1'b1; tick(3);
    wr[2] = 1'b1; tick(20);

    // Reset mid-frame with a word held elsewhere.
    rdy[0] = 1'b0;
    send(0, 9'h05A, 1'b0, -1);
    tick(4);
    cmp("pre_rst_valid", {8'd0, dv[0]}, 9'd1);
    rx[2] = 1'b0;
    tick(40);
    cmp("pre_rst_busy", {8'd0, bz[2]}, 9'd1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      cmp("mid_rst_valid", {8'd0, dv[i]}, 9'd0);
      cmp("mid_rst_dout", dout[i], 9'd0);
      cmp("mid_rst_perr", {8'd0, pe[i]}, 9'd0);
      cmp("mid_rst_busy", {8'd0, bz[i]}, 9'd0);
    end
    rst = 1'b1; rx[2] = 1'b1; rdy[0] = 1'b1;
    tick(5);

    // Randomised traffic with random consumer back-pressure.
    rand_rdy = 1;
    for (int n = 0; n < 30; n++) begin
      int inst;
      inst = int'($urandom_range(0, 2));
      send(inst, 9'($urandom_range(0, 511)), (inst == 1) && ($urandom_range(0, 3) == 0), -1);
      tick(int'($urandom_range(0, 20)));
    end
    rand_rdy = 0;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    tick(50);
    cmp("sched_drained", 9'(sched.size()), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
